// File: rtl/mc_controller.sv
// mc_controller: multicycle control unit for the RV32I subset core
// (lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, jal).
// It sequences the shared-ALU, shared-memory datapath through fetch, decode,
// execute, memory and writeback, and drives the mux selects, write enables
// and the ALU operation for each cycle.
//
// Ports:
//   clk        in   core clock, rising edge
//   reset      in   asynchronous active-high reset, forces Fetch
//   op         in   [6:0] opcode from the instruction register
//   funct3     in   [2:0] Instr[14:12]
//   funct7b5   in   Instr[30]
//   Zero       in   ALU zero flag, used only in BEQ
//   ImmSrc     out  [1:0] immediate format: 00 I, 01 S, 10 B, 11 J
//   ALUSrcA    out  [1:0] 00 PC, 01 OldPC, 10 register A
//   ALUSrcB    out  [1:0] 00 WriteData, 01 ImmExt, 10 constant 4
//   ResultSrc  out  [1:0] 00 ALUOut, 01 Data, 10 ALUResult
//   AdrSrc     out  memory address: 0 PC, 1 Result
//   ALUControl out  [2:0] 000 add, 001 sub, 010 and, 011 or, 101 slt
//   IRWrite, PCWrite, RegWrite, MemWrite  out  datapath write enables
//   Illegal    out  one-cycle pulse in Decode for an unsupported opcode
//   State      out  [3:0] current state encoding for trace
module mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [2:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       Illegal,
    output logic [3:0] State
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRType  = 7'b0110011;
    localparam logic [6:0] OpIType  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StAluWb    = 4'd7,
        StExecuteI = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10
    } state_t;

    state_t state_q, state_d;

    logic [1:0] alu_op;
    logic       pc_update;
    logic       branch;
    logic       ir_write_s;
    logic       reg_write_s;
    logic       mem_write_s;
    logic       illegal_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore outputs
    always_comb begin
        state_d     = StFetch;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        AdrSrc      = 1'b0;
        alu_op      = 2'b00;
        pc_update   = 1'b0;
        branch      = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        mem_write_s = 1'b0;
        illegal_s   = 1'b0;
        case (state_q)
            StFetch: begin
                ir_write_s = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                pc_update  = 1'b1;
                state_d    = StDecode;
            end
            StDecode: begin
                // ALU forms the branch/jump target; ALUOut latches it
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecuteR;
                    OpIType:         state_d = StExecuteI;
                    OpJal:           state_d = StJal;
                    OpBranch:        state_d = StBeq;
                    default: begin
                        state_d   = StFetch;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OpLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                AdrSrc  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                ResultSrc   = 2'b01;
                reg_write_s = 1'b1;
                state_d     = StFetch;
            end
            StMemWrite: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
                state_d     = StFetch;
            end
            StExecuteR: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StExecuteI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                reg_write_s = 1'b1;
                state_d     = StFetch;
            end
            StJal: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
                state_d   = StAluWb;
            end
            StBeq: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
                state_d = StFetch;
            end
            // Unused encodings fall back to Fetch with every output low
            default: state_d = StFetch;
        endcase
    end

    // ALU decoder
    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    // op[5] separates R-type sub from addi with Instr[30] set
                    3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        case (op)
            OpStore:  ImmSrc = 2'b01;
            OpBranch: ImmSrc = 2'b10;
            OpJal:    ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    // Enables are held low for the whole reset interval, not just after the edge
    assign IRWrite  = ir_write_s & ~reset;
    assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;
    assign RegWrite = reg_write_s & ~reset;
    assign MemWrite = mem_write_s & ~reset;
    assign Illegal  = illegal_s & ~reset;
    assign State    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller: random instruction stream, reference model
// expressed as per-instruction state walks and per-mnemonic ALU intent,
// scoreboard queue consumed by an independent monitor.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc;
    logic [2:0] ALUControl;
    logic       IRWrite, PCWrite, RegWrite, MemWrite, Illegal;
    logic [3:0] State;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .AdrSrc     (AdrSrc),
        .ALUControl (ALUControl),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .Illegal    (Illegal),
        .State      (State)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic [1:0] imm;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic       adr;
        logic [2:0] alu;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       ill;
    } exp_t;

    // Mnemonics
    localparam int MnLw = 0, MnSw = 1, MnAdd = 2, MnSub = 3, MnAnd = 4, MnOr = 5, MnSlt = 6,
                   MnAddi = 7, MnAndi = 8, MnOri = 9, MnSlti = 10, MnBeq = 11, MnJal = 12,
                   MnRmisc = 13, MnImisc = 14, MnIll = 15;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Instruction encoding chosen from the mnemonic; don't-care fields randomised
    task automatic encode(input int mn, output logic [6:0] o, output logic [2:0] f3,
                          output logic f7);
        f3 = 3'($urandom);
        f7 = 1'($urandom);
        case (mn)
            MnLw:    o = 7'b0000011;
            MnSw:    o = 7'b0100011;
            MnAdd:   begin o = 7'b0110011; f3 = 3'b000; f7 = 1'b0; end
            MnSub:   begin o = 7'b0110011; f3 = 3'b000; f7 = 1'b1; end
            MnAnd:   begin o = 7'b0110011; f3 = 3'b111; end
            MnOr:    begin o = 7'b0110011; f3 = 3'b110; end
            MnSlt:   begin o = 7'b0110011; f3 = 3'b010; end
            MnAddi:  begin o = 7'b0010011; f3 = 3'b000; end
            MnAndi:  begin o = 7'b0010011; f3 = 3'b111; end
            MnOri:   begin o = 7'b0010011; f3 = 3'b110; end
            MnSlti:  begin o = 7'b0010011; f3 = 3'b010; end
            MnBeq:   o = 7'b1100011;
            MnJal:   o = 7'b1101111;
            MnRmisc, MnImisc: begin
                o = (mn == MnRmisc) ? 7'b0110011 : 7'b0010011;
                case ($urandom_range(0, 3))
                    0: f3 = 3'b001;
                    1: f3 = 3'b011;
                    2: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            default: begin
                case ($urandom_range(0, 5))
                    0: o = 7'b0110111;
                    1: o = 7'b0010111;
                    2: o = 7'b1100111;
                    3: o = 7'b1110011;
                    4: o = 7'b0000000;
                    default: o = 7'b1111111;
                endcase
            end
        endcase
    endtask

    // Operation the instruction intends the ALU to perform when it executes
    function automatic logic [2:0] intent_alu(input int mn);
        case (mn)
            MnSub:          return 3'b001;
            MnAnd, MnAndi:  return 3'b010;
            MnOr, MnOri:    return 3'b011;
            MnSlt, MnSlti:  return 3'b101;
            default:        return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_fmt(input int mn);
        case (mn)
            MnSw:    return 2'b01;
            MnBeq:   return 2'b10;
            MnJal:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // What the datapath must see in a given step of an instruction
    function automatic exp_t expect_step(input int st, input int mn, input logic z);
        exp_t e;
        e     = '0;
        e.st  = 4'(st);
        e.imm = imm_fmt(mn);
        case (st)
            0:  begin e.srcb = 2'b10; e.res = 2'b10; e.irw = 1'b1; e.pcw = 1'b1; end
            1:  begin e.srca = 2'b01; e.srcb = 2'b01; e.ill = (mn == MnIll); end
            2:  begin e.srca = 2'b10; e.srcb = 2'b01; end
            3:  e.adr = 1'b1;
            4:  begin e.res = 2'b01; e.rw = 1'b1; end
            5:  begin e.adr = 1'b1; e.mw = 1'b1; end
            6:  begin e.srca = 2'b10; e.alu = intent_alu(mn); end
            7:  e.rw = 1'b1;
            8:  begin e.srca = 2'b10; e.srcb = 2'b01; e.alu = intent_alu(mn); end
            9:  begin e.srca = 2'b01; e.srcb = 2'b10; e.pcw = 1'b1; end
            default: begin e.srca = 2'b10; e.alu = 3'b001; e.pcw = z; end
        endcase
        return e;
    endfunction

    task automatic walk(input int mn, output int s[$]);
        case (mn)
            MnLw:  s = '{0, 1, 2, 3, 4};
            MnSw:  s = '{0, 1, 2, 5};
            MnAdd, MnSub, MnAnd, MnOr, MnSlt, MnRmisc: s = '{0, 1, 6, 7};
            MnAddi, MnAndi, MnOri, MnSlti, MnImisc:    s = '{0, 1, 8, 7};
            MnJal: s = '{0, 1, 9, 7};
            MnBeq: s = '{0, 1, 10};
            default: s = '{0, 1};
        endcase
    endtask

    // Drive one instruction from its Fetch cycle; called just after a rising edge
    // while the DUT is in Fetch. zmode 0/1 forces Zero, 2 randomises it per cycle.
    task automatic run_instr(input int mn, input int zmode, input int steps);
        int s[$];
        logic [6:0] o;
        logic [2:0] f3;
        logic f7;
        logic z;
        walk(mn, s);
        encode(mn, o, f3, f7);
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        for (int i = 0; i < s.size() && i < steps; i++) begin
            z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            Zero = z;
            sb.push_back(expect_step(s[i], mn, z));
            if (i + 1 < s.size() && i + 1 < steps) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // Monitor: every mid-cycle sample is compared against the oldest expectation
    initial begin
        exp_t e, a;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {State, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
                     IRWrite, PCWrite, RegWrite, MemWrite, Illegal};
                chk($sformatf("step state%0d", e.st), 32'(a), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        op       = 7'b0110111;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        Zero     = 1'b0;
        #12;
        chk("reset state", 32'(State), 32'd0);
        chk("reset enables", 32'({IRWrite, PCWrite, RegWrite, MemWrite, Illegal}), 32'd0);
        chk("reset fetch selects", 32'({ALUSrcB, ResultSrc}), 32'b1010);
        #10;
        reset = 1'b0;
        #1;
        chk("release fetch enables", 32'({State, IRWrite, PCWrite}), 32'b0000_11);
        #3;
        chk("first edge decode", 32'({State, Illegal}), 32'b0001_1);
        @(posedge clk);
        #1;
        chk("illegal back to fetch", 32'({State, Illegal}), 32'd0);

        for (int mn = 0; mn < 16; mn++) begin
            run_instr(mn, 2, 99);
            @(posedge clk);
            #1;
        end
        run_instr(MnBeq, 1, 99);
        @(posedge clk);
        #1;
        run_instr(MnBeq, 0, 99);
        @(posedge clk);
        #1;
        for (int k = 0; k < 300; k++) begin
            run_instr(int'($urandom_range(0, 15)), 2, 99);
            @(posedge clk);
            #1;
        end

        // lw aborted by reset while in MemRead
        run_instr(MnLw, 2, 4);
        @(negedge clk);
        #1;
        reset = 1'b1;
        op = 7'b0110111;
        #1;
        chk("abort state", 32'(State), 32'd0);
        chk("abort enables", 32'({IRWrite, PCWrite, RegWrite, MemWrite, Illegal}), 32'd0);
        @(posedge clk);
        #1;
        chk("abort held", 32'({State, IRWrite, PCWrite, RegWrite, MemWrite}), 32'd0);
        #2;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort no regwrite", 32'({RegWrite, MemWrite}), 32'd0);
        end
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
